// File: rtl/wb_queue_pkg.sv
// ---------------------------------------------------------------------------
// wb_queue_pkg
// Constants and helpers shared by the write-back queue, its interface and its
// forwarding matcher. The address/data widths and the register-zero index are
// the same values the register file uses.
//   WB_AWIDTH  : register address width
//   WB_DWIDTH  : register data width
//   WB_DEPTH   : default number of queue entries
//   REG_ZERO   : index of the hard-wired zero register
//   pushCount  : number of lanes pushing this cycle (0..2)
// ---------------------------------------------------------------------------
package wb_queue_pkg;

    localparam int WB_AWIDTH = 5;
    localparam int WB_DWIDTH = 32;
    localparam int WB_DEPTH  = 4;
    localparam int REG_ZERO  = 0;

    // Two one-bit push flags summed into a two-bit count.
    function automatic logic [1:0] pushCount(input logic p0, input logic p1);
        return {1'b0, p0} + {1'b0, p1};
    endfunction

endpackage

// File: rtl/wb_queue_if.sv
// ---------------------------------------------------------------------------
// wb_queue_if
// Bundles the write-back queue's lane inputs, register-file write port,
// forwarding lookup ports and occupancy output.
//   master : execute/decode side (drives lanes and lookup addresses)
//   slave  : the queue itself
// Signals:
//   w_i_valid0/addr0/data0 : lane 0 (older) result
//   w_i_valid1/addr1/data1 : lane 1 (younger) result
//   w_o_ready              : room for two results
//   w_o_wr_en/addr_rd/data_rd : register file write port
//   w_i_addr_rs/rt, w_o_hit_rs/rt, w_o_data_rs/rt : forwarding lookups
//   w_o_count              : occupied entries
// ---------------------------------------------------------------------------
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int AWIDTH = WB_AWIDTH,
    parameter int DWIDTH = WB_DWIDTH
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic              w_i_valid0;
    logic [AWIDTH-1:0] w_i_addr0;
    logic [DWIDTH-1:0] w_i_data0;
    logic              w_i_valid1;
    logic [AWIDTH-1:0] w_i_addr1;
    logic [DWIDTH-1:0] w_i_data1;
    logic              w_o_ready;
    logic              w_o_wr_en;
    logic [AWIDTH-1:0] w_o_addr_rd;
    logic [DWIDTH-1:0] w_o_data_rd;
    logic [AWIDTH-1:0] w_i_addr_rs;
    logic [AWIDTH-1:0] w_i_addr_rt;
    logic              w_o_hit_rs;
    logic [DWIDTH-1:0] w_o_data_rs;
    logic              w_o_hit_rt;
    logic [DWIDTH-1:0] w_o_data_rt;
    logic [CW-1:0]     w_o_count;

    modport master (
        output w_i_valid0, w_i_addr0, w_i_data0,
        output w_i_valid1, w_i_addr1, w_i_data1,
        output w_i_addr_rs, w_i_addr_rt,
        input  w_o_ready, w_o_wr_en, w_o_addr_rd, w_o_data_rd,
        input  w_o_hit_rs, w_o_data_rs, w_o_hit_rt, w_o_data_rt,
        input  w_o_count
    );

    modport slave (
        input  w_i_valid0, w_i_addr0, w_i_data0,
        input  w_i_valid1, w_i_addr1, w_i_data1,
        input  w_i_addr_rs, w_i_addr_rt,
        output w_o_ready, w_o_wr_en, w_o_addr_rd, w_o_data_rd,
        output w_o_hit_rs, w_o_data_rs, w_o_hit_rt, w_o_data_rt,
        output w_o_count
    );

endinterface

// File: rtl/wb_match.sv
// ---------------------------------------------------------------------------
// wb_match
// Combinational youngest-match search over the queue's entry array, used to
// forward pending results to decode.
//   valid_i  : per-slot occupied flags
//   addr_i   : per-slot destination register
//   data_i   : per-slot result
//   head_i   : slot of the oldest entry
//   lookup_i : register being looked up
//   hit_o    : some occupied entry targets lookup_i (never for register 0)
//   data_o   : data of the youngest matching entry, zero on a miss
// ---------------------------------------------------------------------------
module wb_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int AWIDTH = WB_AWIDTH,
    parameter int DWIDTH = WB_DWIDTH,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][AWIDTH-1:0] addr_i,
    input  logic [DEPTH-1:0][DWIDTH-1:0] data_i,
    input  logic [PTRW-1:0]              head_i,
    input  logic [AWIDTH-1:0]            lookup_i,
    output logic                         hit_o,
    output logic [DWIDTH-1:0]            data_o
);

    logic [PTRW-1:0] idx;

    // Walk the slots from oldest to youngest; a later match overrides an
    // earlier one, so the result ends up being the youngest pending value.
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTRW'(k);
            if (valid_i[idx] && (addr_i[idx] == lookup_i) &&
                (lookup_i != AWIDTH'(REG_ZERO))) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue
// Write-back queue between two execute lanes and a single-write-port register
// file. Up to two results enter per cycle in program order (lane 0 first) and
// one entry drains to the register file every cycle the queue is non-empty.
// Two lookup ports let decode forward pending values.
// Ports:
//   w_clk : clock, all state updates on the rising edge
//   w_rst : synchronous active-high reset, discards all pending entries
//   bus   : wb_queue_if slave (lanes, write port, lookups, count)
// ---------------------------------------------------------------------------
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int AWIDTH = WB_AWIDTH,
    parameter int DWIDTH = WB_DWIDTH
) (
    input  logic       w_clk,
    input  logic       w_rst,
    wb_queue_if.slave  bus
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

    logic [PTRW-1:0]              head_q, head_d;
    logic [PTRW-1:0]              tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][AWIDTH-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DWIDTH-1:0] data_q, data_d;

    logic            ready;
    logic            push0;
    logic            push1;
    logic            pop;
    logic [PTRW-1:0] slot1;

    // Readiness looks only at the registered count, so two free slots are
    // guaranteed even if nothing drains this cycle; this is what makes
    // overflow impossible.
    assign ready = (count_q <= CW'(DEPTH - 2));

    // Writes to register zero are architecturally meaningless and are dropped.
    assign push0 = ready && bus.w_i_valid0 && (bus.w_i_addr0 != AWIDTH'(REG_ZERO));
    assign push1 = ready && bus.w_i_valid1 && (bus.w_i_addr1 != AWIDTH'(REG_ZERO));

    // The register file always accepts, so any valid head drains every cycle.
    assign pop = (count_q != '0);

    // Lane 1 lands right behind lane 0 when both push, otherwise at tail.
    assign slot1 = push0 ? (tail_q + PTR_ONE) : tail_q;

    // Next-state of the circular buffer. The pop clears the head slot before
    // the pushes fill tail slots; those can never be the same slot because a
    // push needs two free slots and a pop needs a non-empty queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q + CW'(pushCount(push0, push1)) - CW'(pop);

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end

        if (push0) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = bus.w_i_addr0;
            data_d[tail_q]  = bus.w_i_data0;
        end

        if (push1) begin
            valid_d[slot1] = 1'b1;
            addr_d[slot1]  = bus.w_i_addr1;
            data_d[slot1]  = bus.w_i_data1;
        end

        tail_d = tail_q + PTRW'(pushCount(push0, push1));
    end

    // State registers; reset empties the queue and clears entry contents so
    // nothing stale can reach the write port or the lookups.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.w_o_ready   = ready;
    assign bus.w_o_wr_en   = pop;
    assign bus.w_o_addr_rd = pop ? addr_q[head_q] : '0;
    assign bus.w_o_data_rd = pop ? data_q[head_q] : '0;
    assign bus.w_o_count   = count_q;

    wb_match #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_match_rs (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
        .data_i   (data_q),
        .head_i   (head_q),
        .lookup_i (bus.w_i_addr_rs),
        .hit_o    (bus.w_o_hit_rs),
        .data_o   (bus.w_o_data_rs)
    );

    wb_match #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_match_rt (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
        .data_i   (data_q),
        .head_i   (head_q),
        .lookup_i (bus.w_i_addr_rt),
        .hit_o    (bus.w_o_hit_rt),
        .data_o   (bus.w_o_data_rt)
    );

endmodule

// File: tb/tb_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_queue
// Self-checking bench for wb_queue. A queue-based reference holds the
// expected register-file writes in program order; a table of hand-derived
// count/ready/lookup values covers the directed scenarios, followed by a
// mid-operation reset sequence and a random burst.
// ---------------------------------------------------------------------------
module tb_wb_queue;

    logic w_clk;
    logic w_rst;

    wb_queue_if #(.DEPTH(4), .AWIDTH(5), .DWIDTH(32)) bus ();

    wb_queue #(
        .DEPTH  (4),
        .AWIDTH (5),
        .DWIDTH (32)
    ) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [2:0]  expCount;
        logic        expReady;
        logic        expHitRs;
        logic [31:0] expDataRs;
        logic        expHitRt;
        logic [31:0] expDataRt;
    } vec_t;

    ent_t model[$];
    vec_t tbl[23];
    int   total = 0;
    int   bad   = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookupModel(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            for (int i = model.size() - 1; i >= 0; i--) begin
                if (model[i].addr == a) begin
                    hit = 1'b1;
                    d   = model[i].data;
                    break;
                end
            end
        end
    endfunction

    // Compare the DUT against the reference as it stands before the edge.
    task automatic checkOutput(input string tag);
        logic        h;
        logic [31:0] d;
        checkVal({tag, "_wr_en"}, 32'(bus.w_o_wr_en), 32'(model.size() != 0));
        checkVal({tag, "_count"}, 32'(bus.w_o_count), 32'(model.size()));
        checkVal({tag, "_ready"}, 32'(bus.w_o_ready), 32'(model.size() <= 2));
        if (model.size() != 0) begin
            checkVal({tag, "_addr_rd"}, 32'(bus.w_o_addr_rd), 32'(model[0].addr));
            checkVal({tag, "_data_rd"}, bus.w_o_data_rd, model[0].data);
        end else begin
            checkVal({tag, "_addr_rd"}, 32'(bus.w_o_addr_rd), 32'd0);
            checkVal({tag, "_data_rd"}, bus.w_o_data_rd, 32'd0);
        end
        lookupModel(bus.w_i_addr_rs, h, d);
        checkVal({tag, "_hit_rs"}, 32'(bus.w_o_hit_rs), 32'(h));
        checkVal({tag, "_data_rs"}, bus.w_o_data_rs, d);
        lookupModel(bus.w_i_addr_rt, h, d);
        checkVal({tag, "_hit_rt"}, 32'(bus.w_o_hit_rt), 32'(h));
        checkVal({tag, "_data_rt"}, bus.w_o_data_rt, d);
    endtask

    // Advance the reference across the coming edge: drain the head, then
    // accept the lanes in program order when two slots were free.
    task automatic updateModel();
        logic rdy;
        rdy = (model.size() <= 2);
        if (model.size() != 0) void'(model.pop_front());
        if (rdy && bus.w_i_valid0 && bus.w_i_addr0 != 5'd0)
            model.push_back('{addr: bus.w_i_addr0, data: bus.w_i_data0});
        if (rdy && bus.w_i_valid1 && bus.w_i_addr1 != 5'd0)
            model.push_back('{addr: bus.w_i_addr1, data: bus.w_i_data1});
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [4:0] rs, input logic [4:0] rt, input string tag);
        @(negedge w_clk);
        bus.w_i_valid0  = v0;
        bus.w_i_addr0   = a0;
        bus.w_i_data0   = d0;
        bus.w_i_valid1  = v1;
        bus.w_i_addr1   = a1;
        bus.w_i_data1   = d1;
        bus.w_i_addr_rs = rs;
        bus.w_i_addr_rt = rt;
        #1;
        checkOutput(tag);
        updateModel();
    endtask

    task automatic applyReset(input int n);
        @(negedge w_clk);
        w_rst          = 1'b1;
        bus.w_i_valid0 = 1'b0;
        bus.w_i_valid1 = 1'b0;
        repeat (n) @(negedge w_clk);
        w_rst = 1'b0;
        model.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        w_rst           = 1'b1;
        bus.w_i_valid0  = 1'b0;
        bus.w_i_addr0   = '0;
        bus.w_i_data0   = '0;
        bus.w_i_valid1  = 1'b0;
        bus.w_i_addr1   = '0;
        bus.w_i_data1   = '0;
        bus.w_i_addr_rs = '0;
        bus.w_i_addr_rt = '0;

        //            v0 a0     d0        v1 a1     d1        rs     rt     cnt  rdy  hrs  drs       hrt  drt
        tbl[0]  = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 3'd1, 1'b1, 1'b1, 32'h33, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6, 3'd2, 1'b1, 1'b1, 32'h55, 1'b1, 32'h66};
        tbl[5]  = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6, 3'd3, 1'b0, 1'b1, 32'h55, 1'b1, 32'h66};
        tbl[6]  = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6, 3'd2, 1'b1, 1'b1, 32'h55, 1'b1, 32'h66};
        tbl[7]  = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6, 3'd3, 1'b0, 1'b1, 32'h55, 1'b1, 32'h66};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd6, 3'd2, 1'b1, 1'b1, 32'h55, 1'b1, 32'h66};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd6, 3'd1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h66};
        tbl[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd6, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[11] = '{1'b1, 5'd7, 32'h10, 1'b1, 5'd7, 32'h20, 5'd7, 5'd7, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd5, 3'd2, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd7, 3'd1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20};
        tbl[14] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd7, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[15] = '{1'b1, 5'd0, 32'hFF, 1'b1, 5'd9, 32'h99, 5'd0, 5'd9, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[16] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd9, 3'd1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h99};
        tbl[17] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd9, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[18] = '{1'b1, 5'd4, 32'h41, 1'b1, 5'd8, 32'h81, 5'd4, 5'd8, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[19] = '{1'b1, 5'd4, 32'h42, 1'b0, 5'd0, 32'h0,  5'd4, 5'd8, 3'd2, 1'b1, 1'b1, 32'h41, 1'b1, 32'h81};
        tbl[20] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 5'd8, 3'd2, 1'b1, 1'b1, 32'h42, 1'b1, 32'h81};
        tbl[21] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 5'd8, 3'd1, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0};
        tbl[22] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 5'd8, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};

        applyReset(2);

        // Idle after reset: empty queue, ready, nothing forwarded.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, "idle");
        checkVal("rst_count", 32'(bus.w_o_count), 32'd0);
        checkVal("rst_ready", 32'(bus.w_o_ready), 32'd1);
        checkVal("rst_wr_en", 32'(bus.w_o_wr_en), 32'd0);

        // Directed table: scoreboard checks the write port every row, the
        // table adds hand-derived occupancy and forwarding values.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                          tbl[i].rs, tbl[i].rt, $sformatf("sb%0d", i));
            checkVal($sformatf("tbl%0d_count", i), 32'(bus.w_o_count), 32'(tbl[i].expCount));
            checkVal($sformatf("tbl%0d_ready", i), 32'(bus.w_o_ready), 32'(tbl[i].expReady));
            checkVal($sformatf("tbl%0d_hit_rs", i), 32'(bus.w_o_hit_rs), 32'(tbl[i].expHitRs));
            checkVal($sformatf("tbl%0d_data_rs", i), bus.w_o_data_rs, tbl[i].expDataRs);
            checkVal($sformatf("tbl%0d_hit_rt", i), 32'(bus.w_o_hit_rt), 32'(tbl[i].expHitRt));
            checkVal($sformatf("tbl%0d_data_rt", i), bus.w_o_data_rt, tbl[i].expDataRt);
        end

        // Reset with three entries pending: everything is discarded.
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0, "mr0");
        applyStimulus(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 5'd0, 5'd0, "mr1");
        @(negedge w_clk);
        w_rst          = 1'b1;
        bus.w_i_valid0 = 1'b0;
        bus.w_i_valid1 = 1'b0;
        #1;
        checkVal("mr_pre_count", 32'(bus.w_o_count), 32'd3);
        @(negedge w_clk);
        w_rst = 1'b0;
        model.delete();
        #1;
        checkVal("mr_post_count", 32'(bus.w_o_count), 32'd0);
        checkVal("mr_post_wr_en", 32'(bus.w_o_wr_en), 32'd0);
        checkVal("mr_post_ready", 32'(bus.w_o_ready), 32'd1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd11, "mr_idle");

        // Random burst with small register numbers to provoke lookups,
        // same-address pairs and register-zero drops.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rnd");
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, "drain");
        checkVal("drain_count", 32'(bus.w_o_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
